imm_gen_stage: RTL and testbench
================================

// Module: imm_gen_stage
// PURPOSE
//  Buffered RV32/RV64 immediate generator for the decode stage, covering all base formats (R/I/S/B/U/J).
//  Accepts instructions over a valid/ready handshake and holds decoded results in a small FIFO.
//  Emits each instruction with its sign-extended immediate, format code and a side-band tag.
//  Sits between the fetch buffer and the register-read stage; flush is driven by branch/jump redirect.
// PARAMETERS
//  XLEN       64  immediate width; legal values are 32 and 64.
//  FIFO_DEPTH 2   entries of decoded-result storage; power of 2, >= 2.
//  TAG_W      8   width of the pass-through tag (PC index / ROB id).
// PORTS
//  clk         in   1               rising-edge clock
//  reset_n     in   1               synchronous, active-low reset
//  flush       in   1               synchronous drop of all buffered entries
//  in_valid    in   1               upstream instruction valid
//  in_ready    out  1               stage can accept this cycle
//  in_instr    in   32              raw instruction word
//  in_tag      in   TAG_W           side-band tag, carried unchanged
//  out_valid   out  1               head entry valid
//  out_ready   in   1               downstream accepts head entry
//  out_instr   out  32              instruction of head entry
//  out_imm     out  XLEN            sign-extended immediate of head entry
//  out_fmt     out  3               0=R 1=I 2=S 3=B 4=U 5=J 7=ILLEGAL
//  out_tag     out  TAG_W           tag of head entry
//  out_level   out  clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): pointers and level cleared. out_valid=0, out_level=0, in_ready=1.
//    out_imm/out_fmt/out_tag/out_instr read 0. Reset overrides flush, push and pop.
//  - Decode is combinational on in_instr; the result is written into the FIFO on push (in_valid & in_ready).
//  - Opcode[6:0] -> format:
//      0000011 0010011 0011011 1100111 1110011 -> I : imm = sext(i[31:20])
//      0100011 -> S : sext({i[31:25], i[11:7]})
//      1100011 -> B : sext({i[31], i[7], i[30:25], i[11:8], 1'b0})
//      0110111 0010111 -> U : sext({i[31:12], 12'b0})
//      1101111 -> J : sext({i[31], i[19:12], i[20], i[30:21], 1'b0})
//      0110011 0111011 -> R : imm = 0
//      any other opcode -> fmt=7, imm = 0; the entry is still buffered and delivered.
//  - Sign extension replicates i[31] up to bit XLEN-1 (U-type is also sign-extended when XLEN=64).
//  - Latency: an entry pushed at edge N is presented with out_valid=1 after edge N. No combinational in->out path.
//  - in_ready = (level < FIFO_DEPTH), from registered state only. When full there is no same-cycle pass-through.
//  - Pop on out_valid & out_ready. Push and pop in the same cycle leave level unchanged. Order is strictly FIFO.
//  - Holding rule: while out_valid=1 & out_ready=0, all out_* fields stay stable.
//  - Pointers wrap modulo FIFO_DEPTH. out_level ranges 0..FIFO_DEPTH.
//  - flush=1 at an edge: level becomes 0 and out_valid=0 on the next cycle.
//    A push in the same cycle is discarded; a pop in the same cycle is still counted by downstream.
// CONFIGURATION
//  IMMGEN_UJ_EN defined:   U-type (LUI/AUIPC) and J-type (JAL) are decoded as listed above.
//  IMMGEN_UJ_EN undefined: opcodes 0110111, 0010111 and 1101111 produce fmt=7 and imm=0. U/J extractors are not built.
// TESTING (XLEN=64, FIFO_DEPTH=2, out_ready=1 unless stated)
//  1. addi 0xFFF00093 -> next cycle out_imm=0xFFFF_FFFF_FFFF_FFFF, out_fmt=1, tag echoed.
//  2. sw 0xFE20AE23 -> out_imm=0xFFFF_FFFF_FFFF_FFFC, out_fmt=2. beq 0xFE000CE3 -> out_imm=...FFF8, out_fmt=3.
//  3. lui 0x800002B7: with IMMGEN_UJ_EN out_imm=0xFFFF_FFFF_8000_0000, out_fmt=4; without it out_fmt=7, out_imm=0.
//  4. out_ready=0, push 3 back-to-back -> in_ready drops after 2 accepts and out_level=2; the third is held.
//     Then out_ready=1 -> all 3 delivered in order, out_* stable while stalled.
//  5. level=1, flush=1 with in_valid=1 -> next cycle out_valid=0, out_level=0; the flushed word never appears.
//  6. reset_n=0 while level=2 -> next cycle out_valid=0, out_level=0, in_ready=1.

Source files
------------

// File: rtl/imm_gen_stage.sv
// Buffered RV32/RV64 immediate generator: decodes R/I/S/B/U/J immediates and queues them in a small FIFO.
// Optional feature macro IMMGEN_UJ_EN enables U-type (LUI/AUIPC) and J-type (JAL) decoding.
module imm_gen_stage #(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_instr,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_instr,
    output logic [XLEN-1:0]               out_imm,
    output logic [2:0]                    out_fmt,
    output logic [TAG_W-1:0]              out_tag,
    output logic [$clog2(FIFO_DEPTH):0]   out_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [2:0] FMT_R       = 3'd0;
    localparam logic [2:0] FMT_I       = 3'd1;
    localparam logic [2:0] FMT_S       = 3'd2;
    localparam logic [2:0] FMT_B       = 3'd3;
    localparam logic [2:0] FMT_U       = 3'd4;
    localparam logic [2:0] FMT_J       = 3'd5;
    localparam logic [2:0] FMT_ILLEGAL = 3'd7;

    // Each extractor first builds a 32-bit sign-correct value; this widens it to XLEN.
    function automatic logic [XLEN-1:0] sext_xlen(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [6:0]       opcode_s;
    logic             sign_s;
    logic [XLEN-1:0]  dec_imm_s;
    logic [2:0]       dec_fmt_s;
    logic             push_s;
    logic             pop_s;

    logic [31:0]      mem_instr_r [FIFO_DEPTH];
    logic [XLEN-1:0]  mem_imm_r   [FIFO_DEPTH];
    logic [2:0]       mem_fmt_r   [FIFO_DEPTH];
    logic [TAG_W-1:0] mem_tag_r   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;

    assign opcode_s = in_instr[6:0];
    assign sign_s   = in_instr[31];

    // Opcode to format and immediate decode of the incoming word.
    always_comb begin
        dec_imm_s = {XLEN{1'b0}};
        dec_fmt_s = FMT_ILLEGAL;
        case (opcode_s)
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
                dec_fmt_s = FMT_I;
                dec_imm_s = sext_xlen({{20{sign_s}}, in_instr[31:20]});
            end
            7'b0100011: begin
                dec_fmt_s = FMT_S;
                dec_imm_s = sext_xlen({{20{sign_s}}, in_instr[31:25], in_instr[11:7]});
            end
            7'b1100011: begin
                dec_fmt_s = FMT_B;
                dec_imm_s = sext_xlen({{19{sign_s}}, sign_s, in_instr[7], in_instr[30:25],
                                       in_instr[11:8], 1'b0});
            end
`ifdef IMMGEN_UJ_EN
            7'b0110111, 7'b0010111: begin
                dec_fmt_s = FMT_U;
                dec_imm_s = sext_xlen({in_instr[31:12], 12'b0});
            end
            7'b1101111: begin
                dec_fmt_s = FMT_J;
                dec_imm_s = sext_xlen({{11{sign_s}}, sign_s, in_instr[19:12], in_instr[20],
                                       in_instr[30:21], 1'b0});
            end
`endif
            7'b0110011, 7'b0111011: begin
                dec_fmt_s = FMT_R;
                dec_imm_s = {XLEN{1'b0}};
            end
            default: begin
                dec_fmt_s = FMT_ILLEGAL;
                dec_imm_s = {XLEN{1'b0}};
            end
        endcase
    end

    assign in_ready  = (level_r < LVL_W'(FIFO_DEPTH));
    assign out_valid = (level_r != {LVL_W{1'b0}});
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;
    assign out_level = level_r;

    // Pointer and occupancy tracking; flush empties the queue and drops a same-cycle push.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Entry storage, written with the decoded result on each accepted push.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_instr_r[k] <= 32'd0;
                mem_imm_r[k]   <= {XLEN{1'b0}};
                mem_fmt_r[k]   <= 3'd0;
                mem_tag_r[k]   <= {TAG_W{1'b0}};
            end
        end else if (push_s && !flush) begin
            mem_instr_r[wr_ptr_r] <= in_instr;
            mem_imm_r[wr_ptr_r]   <= dec_imm_s;
            mem_fmt_r[wr_ptr_r]   <= dec_fmt_s;
            mem_tag_r[wr_ptr_r]   <= in_tag;
        end
    end

    // Head entry presentation; fields read zero while the queue is empty.
    always_comb begin
        if (out_valid) begin
            out_instr = mem_instr_r[rd_ptr_r];
            out_imm   = mem_imm_r[rd_ptr_r];
            out_fmt   = mem_fmt_r[rd_ptr_r];
            out_tag   = mem_tag_r[rd_ptr_r];
        end else begin
            out_instr = 32'd0;
            out_imm   = {XLEN{1'b0}};
            out_fmt   = 3'd0;
            out_tag   = {TAG_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed + randomized scoreboard bench for imm_gen_stage (XLEN=64, FIFO_DEPTH=2, TAG_W=8).
// Honors IMMGEN_UJ_EN the same way as the design build.
module tb_imm_gen_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [7:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, out_instr;
    logic [7:0]  in_tag, out_tag;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic [1:0]  out_level;

    int   checks    = 0;
    int   failures  = 0;
    int   delivered = 0;
    exp_t sb[$];
    exp_t head;

    imm_gen_stage #(.XLEN(64), .FIFO_DEPTH(2), .TAG_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_tag(out_tag), .out_level(out_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode: place the field at the top of a 64-bit word and arithmetic-shift down.
    function automatic exp_t model(input logic [31:0] i, input logic [7:0] t);
        exp_t e;
        logic signed [63:0] w;
        e.instr = i;
        e.tag   = t;
        e.fmt   = 3'd7;
        w       = 64'sd0;
        case (i[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: begin
                e.fmt = 3'd1; w = {i[31:20], 52'd0}; w = w >>> 52;
            end
            7'h23: begin
                e.fmt = 3'd2; w = {i[31:25], i[11:7], 52'd0}; w = w >>> 52;
            end
            7'h63: begin
                e.fmt = 3'd3; w = {i[31], i[7], i[30:25], i[11:8], 1'b0, 51'd0}; w = w >>> 51;
            end
`ifdef IMMGEN_UJ_EN
            7'h37, 7'h17: begin
                e.fmt = 3'd4; w = {i[31:12], 12'd0, 32'd0}; w = w >>> 32;
            end
            7'h6F: begin
                e.fmt = 3'd5; w = {i[31], i[19:12], i[20], i[30:21], 1'b0, 43'd0}; w = w >>> 43;
            end
`endif
            7'h33, 7'h3B: e.fmt = 3'd0;
            default: e.fmt = 3'd7;
        endcase
        e.imm = w;
        return e;
    endfunction

    // Scoreboard: compare the head on every pop, then record what the stage accepts.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_output", 64'd0, 64'd1);
                end else begin
                    head = sb.pop_front();
                    check("sb_instr", {32'd0, out_instr}, {32'd0, head.instr});
                    check("sb_imm", out_imm, head.imm);
                    check("sb_fmt", {61'd0, out_fmt}, {61'd0, head.fmt});
                    check("sb_tag", {56'd0, out_tag}, {56'd0, head.tag});
                    delivered++;
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(model(in_instr, in_tag));
        end
    end

    task automatic send(input logic [31:0] instr, input logic [7:0] tag);
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && out_valid; k++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        logic [6:0]  ops [12];
        logic [31:0] r;
        logic [7:0]  tagc;
        int          d0;
        logic        accepted;
        ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_tag = 8'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_level", {62'd0, out_level}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_imm", out_imm, 64'd0);
        check("rst_fmt_tag_instr", {29'd0, out_fmt, out_tag, out_instr}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic decode, one entry in flight at a time
        send(32'hFFF00093, 8'h11);
        check("addi_valid", {63'd0, out_valid}, 64'd1);
        check("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_fmt", {61'd0, out_fmt}, 64'd1);
        check("addi_tag", {56'd0, out_tag}, 64'h11);
        send(32'hFE20AE23, 8'h22);
        check("sw_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("sw_fmt", {61'd0, out_fmt}, 64'd2);
        send(32'hFE000CE3, 8'h33);
        check("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        check("beq_fmt", {61'd0, out_fmt}, 64'd3);
        send(32'h800002B7, 8'h44);
`ifdef IMMGEN_UJ_EN
        check("lui_imm", out_imm, 64'hFFFF_FFFF_8000_0000);
        check("lui_fmt", {61'd0, out_fmt}, 64'd4);
`else
        check("lui_imm", out_imm, 64'd0);
        check("lui_fmt", {61'd0, out_fmt}, 64'd7);
`endif
        send(32'h00B50533, 8'h45);
        check("add_fmt_imm", {out_fmt, out_imm[60:0]}, {3'd0, 61'd0});
        send(32'h0000007F, 8'h46);
        check("illegal_fmt", {61'd0, out_fmt}, 64'd7);
        drain();

        // Randomized traffic with back-pressure, wrap-around and occasional flush
        tagc = 8'h80;
        for (int n = 0; n < 200; n++) begin
            r         = $urandom();
            in_instr  = {r[31:7], ops[$urandom_range(0, 11)]};
            in_tag    = tagc;
            tagc      = tagc + 8'd1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        drain();

        // Full-queue stall: two accepted, third held, outputs stable
        out_ready = 1'b0;
        d0 = delivered;
        send(32'h00100093, 8'hA1);
        send(32'h00C12223, 8'hB2);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        check("full_level", {62'd0, out_level}, 64'd2);
        in_valid = 1'b1; in_instr = 32'h00208463; in_tag = 8'hC3;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("stall_level", {62'd0, out_level}, 64'd2);
            check("stall_instr", {32'd0, out_instr}, 64'h0010_0093);
            check("stall_imm", out_imm, 64'd1);
            check("stall_tag", {56'd0, out_tag}, 64'hA1);
        end
        out_ready = 1'b1;
        accepted  = 1'b0;
        for (int k = 0; k < 6 && !accepted; k++) begin
            if (in_ready) accepted = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("third_accepted", {63'd0, accepted}, 64'd1);
        drain();
        check("stall_delivered", delivered - d0, 64'd3);

        // Flush at level 1 with a simultaneous push and pop
        out_ready = 1'b0;
        d0 = delivered;
        send(32'h00200113, 8'h55);
        check("pre_flush_level", {62'd0, out_level}, 64'd1);
        in_valid = 1'b1; in_instr = 32'h00300193; in_tag = 8'h66;
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_level", {62'd0, out_level}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("flush_stays_empty", {63'd0, out_valid}, 64'd0);
        end
        check("flush_pop_counted", delivered - d0, 64'd1);

        // Reset while full overrides push and pop
        out_ready = 1'b0;
        send(32'h00400213, 8'h71);
        send(32'h00500293, 8'h72);
        check("pre_rst_level", {62'd0, out_level}, 64'd2);
        reset_n = 1'b0; in_valid = 1'b1; in_instr = 32'h00600313; out_ready = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1; in_valid = 1'b0;
        check("rst2_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst2_level", {62'd0, out_level}, 64'd0);
        check("rst2_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst2_imm", out_imm, 64'd0);
        check("rst2_instr", {32'd0, out_instr}, 64'd0);
        send(32'hFFF00093, 8'h7A);
        check("post_rst_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();
        check("sb_all_delivered", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
